// File: rtl/decoder_pkg.sv
// Shared constants for the registered one-hot decoder.
//   DEC_SEL_W : width of the binary select
//   DEC_OUT_W : width of the one-hot word (2**DEC_SEL_W)
//   DEC_ZERO  : all-low one-hot word used for reset and disable
package decoder_pkg;

   localparam int DEC_SEL_W = 3;
   localparam int DEC_OUT_W = 2 ** DEC_SEL_W;
   localparam logic [DEC_OUT_W-1:0] DEC_ZERO = '0;

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot core.
// Ports:
//   sel : binary select, unsigned
//   en  : active-high enable; when low the word is all zeros
//   dec : one-hot result, bit i high <=> en and sel == i
module onehot_dec
   import decoder_pkg::*;
#(
   parameter int SEL_W = DEC_SEL_W,
   parameter int OUT_W = 2 ** SEL_W
) (
   input  logic [SEL_W-1:0] sel,
   input  logic             en,
   output logic [OUT_W-1:0] dec
);

   // Per-bit equality compare rather than a shift: an unknown select never
   // sets more than one bit, it simply fails every compare.
   always_comb begin
      dec = '0;
      if (en) begin
         for (int i = 0; i < OUT_W; i++) begin
            if (sel == SEL_W'(i)) begin
               dec[i] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/decoder_3_8.sv
// Registered 3-to-8 one-hot decoder with active-high enable.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset, priority over en/in
//   in  : binary select 0..7
//   en  : active-high decode enable
//   out : registered one-hot result, one cycle after (in, en) is sampled
module decoder_3_8
   import decoder_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DEC_SEL_W-1:0] in,
   input  logic                 en,
   output logic [DEC_OUT_W-1:0] out
);

   logic [DEC_OUT_W-1:0] dec;

   onehot_dec #(
      .SEL_W (DEC_SEL_W),
      .OUT_W (DEC_OUT_W)
   ) u_core (
      .sel (in),
      .en  (en),
      .dec (dec)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out <= DEC_ZERO;
      end else begin
         out <= dec;
      end
   end

endmodule

// File: tb/tb_decoder_3_8.sv
module tb_decoder_3_8;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] in;
   logic       en;
   logic [7:0] out;

   int n_chk = 0;
   int n_bad = 0;

   decoder_3_8 dut (
      .clk (clk),
      .rst (rst),
      .in  (in),
      .en  (en),
      .out (out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; samples and drives happen 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] sweep_exp [8];
   logic [2:0] in_d;
   logic       en_d;
   logic [7:0] exp_r;

   initial begin
      sweep_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

      // reset held two cycles with a live decode request
      rst = 1'b1; en = 1'b1; in = 3'd5;
      tick();
      check("rst_c1", out, 8'h00);
      tick();
      check("rst_c2", out, 8'h00);
      rst = 1'b0;
      check("rst_rel", out, 8'h00);
      tick();
      check("first_dec", out, 8'h20);

      // full sweep
      for (int i = 0; i < 8; i++) begin
         in = 3'(i);
         tick();
         check($sformatf("sweep%0d", i), out, sweep_exp[i]);
      end

      // enable drop with select held
      en = 1'b1; in = 3'd4;
      tick();
      check("en_hi", out, 8'h10);
      en = 1'b0;
      tick();
      check("en_lo", out, 8'h00);
      in = 3'd7;
      tick();
      check("en_lo_in7", out, 8'h00);

      // reset mid-sweep
      en = 1'b1; in = 3'd5;
      tick();
      check("pre_rst", out, 8'h20);
      in = 3'd6; rst = 1'b1;
      tick();
      check("mid_rst", out, 8'h00);
      rst = 1'b0;
      tick();
      check("post_rst", out, 8'h40);

      // input change between edges must not reach out
      in = 3'd2;
      tick();
      check("hold_pre", out, 8'h04);
      #2 in = 3'd7;
      #1 check("hold_mid", out, 8'h04);
      tick();
      check("hold_post", out, 8'h80);

      // unknown select while enabled must not give multiple-hot
      in = 3'bxx1;
      tick();
      check("x_sel_pop", 8'($countones(out) <= 1), 8'h01);
      in = 3'd3;
      tick();
      check("after_x", out, 8'h08);

      // random traffic against a 1-cycle delayed reference
      for (int k = 0; k < 200; k++) begin
         in_d = 3'($urandom_range(0, 7));
         en_d = 1'($urandom_range(0, 1));
         in = in_d;
         en = en_d;
         tick();
         exp_r = en_d ? (8'h01 << in_d) : 8'h00;
         check("rand_val", out, exp_r);
         check("rand_pop", 8'($countones(out) <= 1), 8'h01);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
